// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard controller for the 5-stage core. It keeps a
// shadow copy of the EXE, MEM and WB instructions. From these it drives the
// operand forwarding selects for the instruction now in EXE. It also decides
// whether the ID-stage instruction must be held while a bubble enters EXE.
//
// Configuration macro: FWD_HAZARD_FORWARD_EN
//   defined   : forwarding from MEM (select 1) and WB (select 2). The only
//               stall is one bubble per load-use pair.
//   undefined : all selects are tied to 0 (full interlock). A dependent
//               instruction waits in ID until its producer has left WB.
//
// Select encoding: 0 = own operand, 1 = ALU_res_MEM, 2 = result_WB.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   freeze             global hold; every entry and stall_cnt keep value
//   id_valid           ID holds a real instruction
//   id_src1/id_src2    ID source registers (src2 live when id_src2_used)
//   id_is_store        ID is a store; id_st_src is live
//   id_st_src          store-data register
//   id_dest/id_wb_en   ID destination and its write enable
//   id_mem_read        ID is a load
//   val1_sel           forwarding select for val1 of the EXE instruction
//   val2_sel           forwarding select for val2 of the EXE instruction
//   ST_val_sel         forwarding select for store data of the EXE instr.
//   hazard_stall       hold PC and IF/ID; ID/EXE loads a bubble
//   stall_cnt          saturating count of non-frozen stall cycles
//
// Handshake: none. hazard_stall is a level signal. The pipeline treats it
// as "ID not accepted this cycle". It only takes effect on an edge with
// freeze=0.
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int REG_ADDR_LEN    = 5,
    parameter int FORWARD_SEL_LEN = 2,
    parameter int CNT_LEN         = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       freeze,
    input  logic                       id_valid,
    input  logic [REG_ADDR_LEN-1:0]    id_src1,
    input  logic [REG_ADDR_LEN-1:0]    id_src2,
    input  logic                       id_src2_used,
    input  logic                       id_is_store,
    input  logic [REG_ADDR_LEN-1:0]    id_st_src,
    input  logic [REG_ADDR_LEN-1:0]    id_dest,
    input  logic                       id_wb_en,
    input  logic                       id_mem_read,
    output logic [FORWARD_SEL_LEN-1:0] val1_sel,
    output logic [FORWARD_SEL_LEN-1:0] val2_sel,
    output logic [FORWARD_SEL_LEN-1:0] ST_val_sel,
    output logic                       hazard_stall,
    output logic [CNT_LEN-1:0]         stall_cnt
);

    localparam logic [FORWARD_SEL_LEN-1:0] SEL_OWN = '0;
    localparam logic [FORWARD_SEL_LEN-1:0] SEL_MEM = FORWARD_SEL_LEN'(1);
    localparam logic [FORWARD_SEL_LEN-1:0] SEL_WB  = FORWARD_SEL_LEN'(2);

    // EXE entry: producer fields plus the consumer fields used by the selects.
    logic                    exe_valid_q,     exe_valid_d;
    logic [REG_ADDR_LEN-1:0] exe_dest_q,      exe_dest_d;
    logic                    exe_wb_en_q,     exe_wb_en_d;
    logic                    exe_mem_read_q,  exe_mem_read_d;
    logic [REG_ADDR_LEN-1:0] exe_src1_q,      exe_src1_d;
    logic [REG_ADDR_LEN-1:0] exe_src2_q,      exe_src2_d;
    logic [REG_ADDR_LEN-1:0] exe_st_src_q,    exe_st_src_d;
    logic                    exe_src2_used_q, exe_src2_used_d;
    logic                    exe_is_store_q,  exe_is_store_d;

    // MEM and WB entries only act as producers. Their load flag is never
    // consulted: a load that has reached MEM no longer creates a load-use
    // bubble. So only valid/dest/wb_en are kept.
    logic                    mem_valid_q, wb_valid_q;
    logic [REG_ADDR_LEN-1:0] mem_dest_q,  wb_dest_q;
    logic                    mem_wb_en_q, wb_wb_en_q;

    logic [CNT_LEN-1:0]      stall_cnt_q, stall_cnt_d;

    // A producer matches a source when it really writes that register.
    // Register 0 is hard-wired and never forwards or stalls.
    function automatic logic producer_hit(
        input logic                    p_valid,
        input logic                    p_wb_en,
        input logic [REG_ADDR_LEN-1:0] p_dest,
        input logic [REG_ADDR_LEN-1:0] src
    );
        return p_valid && p_wb_en && (p_dest == src) && (src != '0);
    endfunction

    // A producer hits the ID instruction if it matches any live ID source.
    function automatic logic id_dep(
        input logic                    p_valid,
        input logic                    p_wb_en,
        input logic [REG_ADDR_LEN-1:0] p_dest
    );
        return producer_hit(p_valid, p_wb_en, p_dest, id_src1)
            || (id_src2_used && producer_hit(p_valid, p_wb_en, p_dest, id_src2))
            || (id_is_store  && producer_hit(p_valid, p_wb_en, p_dest, id_st_src));
    endfunction

    logic exe_hits_id;
    logic mem_hits_id;
    logic wb_hits_id;

    always_comb begin
        exe_hits_id = id_dep(exe_valid_q, exe_wb_en_q, exe_dest_q);
        mem_hits_id = id_dep(mem_valid_q, mem_wb_en_q, mem_dest_q);
        wb_hits_id  = id_dep(wb_valid_q,  wb_wb_en_q,  wb_dest_q);
    end

`ifdef FWD_HAZARD_FORWARD_EN
    // MEM is checked first, so the younger result wins when both match.
    function automatic logic [FORWARD_SEL_LEN-1:0] pick_sel(
        input logic                    live,
        input logic [REG_ADDR_LEN-1:0] src
    );
        logic [FORWARD_SEL_LEN-1:0] sel;
        sel = SEL_OWN;
        if (live) begin
            if (producer_hit(mem_valid_q, mem_wb_en_q, mem_dest_q, src)) begin
                sel = SEL_MEM;
            end else if (producer_hit(wb_valid_q, wb_wb_en_q, wb_dest_q, src)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        val1_sel   = pick_sel(exe_valid_q,                    exe_src1_q);
        val2_sel   = pick_sel(exe_valid_q && exe_src2_used_q, exe_src2_q);
        ST_val_sel = pick_sel(exe_valid_q && exe_is_store_q,  exe_st_src_q);
    end

    // Only a load still in EXE has no result to forward yet.
    assign hazard_stall = id_valid && exe_mem_read_q && exe_hits_id;
`else
    // Full interlock: no bypass network. The consumer waits until its
    // producer has written the register file.
    assign val1_sel     = SEL_OWN;
    assign val2_sel     = SEL_OWN;
    assign ST_val_sel   = SEL_OWN;
    assign hazard_stall = id_valid && (exe_hits_id || mem_hits_id || wb_hits_id);

    // Consumer-side EXE fields only feed the bypass selects.
    logic unused_exe_fields;
    assign unused_exe_fields = ^{exe_src1_q, exe_src2_q, exe_st_src_q,
                                 exe_src2_used_q, exe_is_store_q, exe_mem_read_q};
`endif

    // Next EXE entry: the ID instruction, or an all-zero bubble on a stall.
    always_comb begin
        exe_valid_d     = 1'b0;
        exe_dest_d      = '0;
        exe_wb_en_d     = 1'b0;
        exe_mem_read_d  = 1'b0;
        exe_src1_d      = '0;
        exe_src2_d      = '0;
        exe_st_src_d    = '0;
        exe_src2_used_d = 1'b0;
        exe_is_store_d  = 1'b0;
        if (!hazard_stall) begin
            exe_valid_d     = id_valid;
            exe_dest_d      = id_dest;
            exe_wb_en_d     = id_wb_en;
            exe_mem_read_d  = id_mem_read;
            exe_src1_d      = id_src1;
            exe_src2_d      = id_src2;
            exe_st_src_d    = id_st_src;
            exe_src2_used_d = id_src2_used;
            exe_is_store_d  = id_is_store;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid_q     <= 1'b0;
            exe_dest_q      <= '0;
            exe_wb_en_q     <= 1'b0;
            exe_mem_read_q  <= 1'b0;
            exe_src1_q      <= '0;
            exe_src2_q      <= '0;
            exe_st_src_q    <= '0;
            exe_src2_used_q <= 1'b0;
            exe_is_store_q  <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_dest_q      <= '0;
            mem_wb_en_q     <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_dest_q       <= '0;
            wb_wb_en_q      <= 1'b0;
            stall_cnt_q     <= '0;
        end else if (!freeze) begin
            wb_valid_q      <= mem_valid_q;
            wb_dest_q       <= mem_dest_q;
            wb_wb_en_q      <= mem_wb_en_q;
            mem_valid_q     <= exe_valid_q;
            mem_dest_q      <= exe_dest_q;
            mem_wb_en_q     <= exe_wb_en_q;
            exe_valid_q     <= exe_valid_d;
            exe_dest_q      <= exe_dest_d;
            exe_wb_en_q     <= exe_wb_en_d;
            exe_mem_read_q  <= exe_mem_read_d;
            exe_src1_q      <= exe_src1_d;
            exe_src2_q      <= exe_src2_d;
            exe_st_src_q    <= exe_st_src_d;
            exe_src2_used_q <= exe_src2_used_d;
            exe_is_store_q  <= exe_is_store_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// Bench for fwd_hazard_unit. A cycle model of the three pipeline entries
// predicts {val1_sel, val2_sel, ST_val_sel, hazard_stall, stall_cnt} for every
// cycle. Directed scenarios add fixed expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int RL = 5;
  localparam int SL = 2;
  localparam int CL = 16;
  localparam int EW = 3 * SL + 1 + CL;
`ifdef FWD_HAZARD_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          freeze;
  logic          id_valid;
  logic [RL-1:0] id_src1;
  logic [RL-1:0] id_src2;
  logic          id_src2_used;
  logic          id_is_store;
  logic [RL-1:0] id_st_src;
  logic [RL-1:0] id_dest;
  logic          id_wb_en;
  logic          id_mem_read;
  logic [SL-1:0] val1_sel;
  logic [SL-1:0] val2_sel;
  logic [SL-1:0] ST_val_sel;
  logic          hazard_stall;
  logic [CL-1:0] stall_cnt;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .REG_ADDR_LEN    (RL),
    .FORWARD_SEL_LEN (SL),
    .CNT_LEN         (CL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src2_used (id_src2_used),
    .id_is_store  (id_is_store),
    .id_st_src    (id_st_src),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_read  (id_mem_read),
    .val1_sel     (val1_sel),
    .val2_sel     (val2_sel),
    .ST_val_sel   (ST_val_sel),
    .hazard_stall (hazard_stall),
    .stall_cnt    (stall_cnt)
  );

  // ---------------- model ----------------
  typedef struct packed {
    logic          v;
    logic [RL-1:0] s1;
    logic [RL-1:0] s2;
    logic          s2u;
    logic          ist;
    logic [RL-1:0] st;
    logic [RL-1:0] dest;
    logic          wb;
    logic          mr;
  } ins_t;

  ins_t          m_exe, m_mem, m_wb, cur_id;
  logic [CL-1:0] m_cnt;
  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic hit(input ins_t p, input logic [RL-1:0] s);
    return p.v && p.wb && (p.dest == s) && (s != '0);
  endfunction

  function automatic logic uses(input ins_t p, input ins_t c);
    return hit(p, c.s1) || (c.s2u && hit(p, c.s2)) || (c.ist && hit(p, c.st));
  endfunction

  function automatic logic [SL-1:0] m_sel(input logic [RL-1:0] s, input logic live);
    logic [SL-1:0] r;
    r = '0;
    if (m_exe.v && live) begin
      if (hit(m_mem, s))     r = 2'd1;
      else if (hit(m_wb, s)) r = 2'd2;
    end
    return FWD_EN ? r : '0;
  endfunction

  function automatic logic m_stall();
    if (!cur_id.v) return 1'b0;
    if (FWD_EN) return m_exe.mr && uses(m_exe, cur_id);
    return uses(m_exe, cur_id) || uses(m_mem, cur_id) || uses(m_wb, cur_id);
  endfunction

  task automatic model_reset();
    m_exe = '0;
    m_mem = '0;
    m_wb  = '0;
    m_cnt = '0;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_id(input ins_t i);
    cur_id       = i;
    id_valid     = i.v;
    id_src1      = i.s1;
    id_src2      = i.s2;
    id_src2_used = i.s2u;
    id_is_store  = i.ist;
    id_st_src    = i.st;
    id_dest      = i.dest;
    id_wb_en     = i.wb;
    id_mem_read  = i.mr;
  endtask

  function automatic ins_t alu(input int d, input int a, input int b, input logic b_used);
    ins_t r;
    r      = '0;
    r.v    = 1'b1;
    r.dest = d[RL-1:0];
    r.s1   = a[RL-1:0];
    r.s2   = b[RL-1:0];
    r.s2u  = b_used;
    r.wb   = 1'b1;
    return r;
  endfunction

  function automatic ins_t load(input int d, input int a);
    ins_t r;
    r    = alu(d, a, 0, 1'b0);
    r.mr = 1'b1;
    return r;
  endfunction

  function automatic ins_t store(input int a, input int sd);
    ins_t r;
    r     = '0;
    r.v   = 1'b1;
    r.s1  = a[RL-1:0];
    r.ist = 1'b1;
    r.st  = sd[RL-1:0];
    return r;
  endfunction

  function automatic ins_t nop();
    ins_t r;
    r   = '0;
    r.v = 1'b1;
    return r;
  endfunction

  function automatic ins_t rand_ins();
    ins_t r;
    r      = '0;
    r.v    = ($urandom_range(0, 5) != 0);
    r.s1   = RL'($urandom_range(0, 3));
    r.s2   = RL'($urandom_range(0, 3));
    r.st   = RL'($urandom_range(0, 3));
    r.dest = RL'($urandom_range(0, 3));
    r.s2u  = 1'($urandom_range(0, 1));
    r.ist  = 1'($urandom_range(0, 1));
    r.wb   = 1'($urandom_range(0, 1));
    r.mr   = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // One cycle, entered and left #1 after a rising edge. The expectation is
  // queued while the inputs are stable. It is popped and compared on the
  // falling edge. The model then advances on the rising edge.
  task automatic step(output logic stl);
    logic [EW-1:0] e;
    stl = m_stall();
    exp_q.push_back({m_sel(m_exe.s1, 1'b1), m_sel(m_exe.s2, m_exe.s2u),
                     m_sel(m_exe.st, m_exe.ist), stl, m_cnt});
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("cycle", 32'({val1_sel, val2_sel, ST_val_sel, hazard_stall, stall_cnt}), 32'(e));
    @(posedge clk);
    if (!freeze) begin
      m_wb  = m_mem;
      m_mem = m_exe;
      m_exe = stl ? '0 : cur_id;
      if (stl && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
    end
    #1;
  endtask

  // Present an instruction in ID and keep it there until it is accepted.
  task automatic issue(input ins_t i);
    logic stl;
    int   n;
    drive_id(i);
    n = 0;
    do begin
      step(stl);
      n++;
    end while (stl && (n < 20));
    check_eq("stall_bound", 32'(stl), 32'd0);
  endtask

  task automatic drain();
    repeat (3) issue(nop());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stl;
    logic prev_hold;

    rst_n  = 1'b0;
    freeze = 1'b0;
    drive_id('0);
    model_reset();
    #1;
    check_eq("rst_stall", 32'(hazard_stall), 32'd0);
    check_eq("rst_cnt",   32'(stall_cnt),    32'd0);
    check_eq("rst_sels",  32'({val1_sel, val2_sel, ST_val_sel}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_cnt",  32'(stall_cnt), 32'd0);
    check_eq("post_rst_sels", 32'({val1_sel, val2_sel, ST_val_sel}), 32'd0);

    // Back-to-back dependency on src1.
    issue(alu(3, 1, 2, 1'b1));
    issue(alu(6, 3, 0, 1'b0));
    check_eq("b2b_val1", 32'(val1_sel),  FWD_EN ? 32'd1 : 32'd0);
    check_eq("b2b_cnt",  32'(stall_cnt), FWD_EN ? 32'd0 : 32'd3);
    drain();

    // Distance-two dependency on src2, then the same with src2 unused.
    issue(alu(3, 1, 2, 1'b1));
    issue(nop());
    issue(alu(7, 1, 3, 1'b1));
    check_eq("d2_val2", 32'(val2_sel),  FWD_EN ? 32'd2 : 32'd0);
    check_eq("d2_cnt",  32'(stall_cnt), FWD_EN ? 32'd0 : 32'd5);
    drain();
    issue(alu(3, 1, 2, 1'b1));
    issue(nop());
    issue(alu(7, 1, 3, 1'b0));
    check_eq("d2_imm_val2", 32'(val2_sel), 32'd0);
    drain();

    // Load-use pair.
    issue(load(5, 1));
    drive_id(alu(8, 5, 0, 1'b0));
    #1;
    check_eq("lu_stall", 32'(hazard_stall), 32'd1);
    issue(alu(8, 5, 0, 1'b0));
    check_eq("lu_val1", 32'(val1_sel),  FWD_EN ? 32'd2 : 32'd0);
    check_eq("lu_cnt",  32'(stall_cnt), FWD_EN ? 32'd1 : 32'd8);
    drain();

    // Two producers of r4 in flight; the store must take the MEM copy.
    issue(alu(4, 1, 2, 1'b1));
    issue(alu(4, 1, 2, 1'b1));
    issue(store(1, 4));
    check_eq("st_prio", 32'(ST_val_sel), FWD_EN ? 32'd1 : 32'd0);
    check_eq("st_cnt",  32'(stall_cnt),  FWD_EN ? 32'd1 : 32'd11);

    // Register 0 never forwards.
    issue(alu(0, 1, 2, 1'b1));
    issue(alu(9, 0, 0, 1'b1));
    check_eq("r0_sels", 32'({val1_sel, val2_sel, ST_val_sel}), 32'd0);
    issue(store(0, 0));
    check_eq("r0_st", 32'(ST_val_sel), 32'd0);
    drain();

    // Load-use held under freeze for three cycles.
    issue(load(10, 1));
    drive_id(alu(11, 10, 0, 1'b0));
    freeze = 1'b1;
    repeat (3) step(stl);
    check_eq("frz_cnt",   32'(stall_cnt),    FWD_EN ? 32'd1 : 32'd11);
    check_eq("frz_stall", 32'(hazard_stall), 32'd1);
    freeze = 1'b0;
    issue(alu(11, 10, 0, 1'b0));
    check_eq("frz_rel_cnt",  32'(stall_cnt), FWD_EN ? 32'd2 : 32'd14);
    check_eq("frz_rel_val1", 32'(val1_sel),  FWD_EN ? 32'd2 : 32'd0);
    drain();

    // Reset in the middle of a stall.
    issue(load(12, 1));
    drive_id(alu(13, 12, 0, 1'b0));
    #1;
    check_eq("mid_rst_pre", 32'(hazard_stall), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_stall", 32'(hazard_stall), 32'd0);
    check_eq("mid_rst_sels",  32'({val1_sel, val2_sel, ST_val_sel}), 32'd0);
    check_eq("mid_rst_cnt",   32'(stall_cnt), 32'd0);
    model_reset();
    drive_id('0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic on a small register set, with random freezes.
    stl       = 1'b0;
    prev_hold = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!prev_hold) drive_id(rand_ins());
      freeze = ($urandom_range(0, 4) == 0);
      step(stl);
      prev_hold = stl || freeze;
    end
    freeze = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
